// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared FSM states, byte-count codes and port ids for the memory initiator
package mem_bus_pkg;
    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;
    typedef enum logic {P_FETCH, P_DAT} port_t;
    localparam logic [1:0] BC_BYTE = 2'd0;
    localparam logic [1:0] BC_HALF = 2'd1;
    localparam logic [1:0] BC_3    = 2'd2;
    localparam logic [1:0] BC_WORD = 2'd3;
endpackage

// File: rtl/load_extend.sv
// load_extend: zero/sign-extends the low bc+1 bytes of a read word
//  data in DATA_W raw read word, bc in 2 byte count - 1, sgn in 1 sign-extend, ext out DATA_W result
module load_extend import mem_bus_pkg::*; #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        bc,
    input  logic              sgn,
    output logic [DATA_W-1:0] ext
);
    logic msb;
    always_comb begin
        msb = bc == BC_BYTE ? data[7] : bc == BC_HALF ? data[15] : bc == BC_3 ? data[23] : data[31];
        ext = '0;
        for (int i = 0; i < DATA_W; i++) ext[i] = i < 8 * (int'(bc) + 1) ? data[i] : sgn & msb;
    end
endmodule

// File: rtl/mem_initiator.sv
// mem_initiator: arbitrates fetch and load/store ports onto one mmu read/write/byteCount/ready bus
//  clk, rst (sync, active-low); fetch_req/addr -> fetch_ack/data; dat_req/we/addr/size/signed/wdata
//  -> dat_ack/rdata; err, busy; mem_addr/read/write/byte_count/wdata out, mem_rdata/_rdy, mem_wdata_rdy in
module mem_initiator import mem_bus_pkg::*; #(
    parameter int         ADDR_W   = 24,
    parameter int         DATA_W   = 32,
    parameter int         TIMEOUT  = 64,
    parameter logic [1:0] FETCH_BC = BC_WORD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ack,
    output logic [DATA_W-1:0] fetch_data,
    input  logic              dat_req,
    input  logic              dat_we,
    input  logic [ADDR_W-1:0] dat_addr,
    input  logic [1:0]        dat_size,
    input  logic              dat_signed,
    input  logic [DATA_W-1:0] dat_wdata,
    output logic              dat_ack,
    output logic [DATA_W-1:0] dat_rdata,
    output logic              err,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [1:0]        mem_byte_count,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdata_rdy,
    input  logic              mem_wdata_rdy
);
    localparam int CW = $clog2(TIMEOUT);
    state_t            state, nxt;
    port_t             port_q;
    logic [CW-1:0]     cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        bc_q;
    logic [DATA_W-1:0] wdata_q, rdata_q, ext;
    logic              we_q, sgn_q, err_q, grant, done_ok, tmo;
    always_comb begin
        grant   = state == S_IDLE && (dat_req || fetch_req);
        // only the ready matching the op completes; the other is ignored
        done_ok = state == S_BUS && (we_q ? mem_wdata_rdy : mem_rdata_rdy);
        tmo     = state == S_BUS && !done_ok && cnt == CW'(TIMEOUT - 1);
        nxt     = state == S_IDLE ? (grant ? S_BUS : S_IDLE) :
                  state == S_BUS  ? (done_ok || tmo ? S_DONE : S_BUS) : S_IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            port_q  <= P_FETCH;
            cnt     <= '0;
            addr_q  <= '0;
            bc_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            sgn_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= nxt;
            if (grant) begin
                // data port wins ties; fetches are always unsigned full reads
                port_q  <= dat_req ? P_DAT : P_FETCH;
                addr_q  <= dat_req ? dat_addr : fetch_addr;
                bc_q    <= dat_req ? dat_size : FETCH_BC;
                wdata_q <= dat_req ? dat_wdata : '0;
                we_q    <= dat_req && dat_we;
                sgn_q   <= dat_req && dat_signed;
                cnt     <= '0;
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
            if (state == S_BUS) begin
                cnt   <= cnt + 1'b1;
                err_q <= tmo;
                if (done_ok && !we_q) rdata_q <= mem_rdata;
            end
        end
    end
    load_extend #(.DATA_W(DATA_W)) u_ext (.data(rdata_q), .bc(bc_q), .sgn(sgn_q), .ext(ext));
    assign busy           = state != S_IDLE;
    assign mem_read       = state == S_BUS && !we_q;
    assign mem_write      = state == S_BUS && we_q;
    assign mem_addr       = addr_q;
    assign mem_byte_count = bc_q;
    assign mem_wdata      = wdata_q;
    assign fetch_ack      = state == S_DONE && port_q == P_FETCH;
    assign dat_ack        = state == S_DONE && port_q == P_DAT;
    assign err            = state == S_DONE && err_q;
    assign fetch_data     = fetch_ack ? ext : '0;
    assign dat_rdata      = dat_ack ? ext : '0;
endmodule

// File: tb/tb_mem_initiator.sv
// tb_mem_initiator: directed checks of mem_initiator against a simple mmu-style responder
module tb_mem_initiator;
    logic        clk = 0, rst = 0;
    logic        fetch_req = 0, dat_req = 0, dat_we = 0, dat_signed = 0;
    logic [23:0] fetch_addr = 0, dat_addr = 0, mem_addr;
    logic [1:0]  dat_size = 0, mem_byte_count;
    logic [31:0] dat_wdata = 0, fetch_data, dat_rdata, mem_wdata, mem_rdata;
    logic        fetch_ack, dat_ack, err, busy, mem_read, mem_write, mem_rdata_rdy, mem_wdata_rdy;
    logic        rsp_en = 1, noise_r = 0, noise_w = 0;
    logic [31:0] rsp_data = 0;
    int          scnt = 0;
    int          passed = 0, fails = 0, total = 0;
    int          ack_cyc, rd_cnt, wr_cnt;
    logic        got_fetch, got_dat, got_err;
    logic [31:0] got_data, wdata_seen;
    logic [23:0] addr_seen;
    logic [1:0]  bc_seen;

    always #5 clk = ~clk;

    // responder: ready in the (bc+3)th strobe cycle
    always @(posedge clk) scnt <= (mem_read || mem_write) ? scnt + 1 : 0;
    assign mem_rdata     = rsp_data;
    assign mem_rdata_rdy = (rsp_en && mem_read && scnt == int'(mem_byte_count) + 2) || noise_r;
    assign mem_wdata_rdy = (rsp_en && mem_write && scnt == int'(mem_byte_count) + 2) || noise_w;

    mem_initiator dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_data(fetch_data),
        .dat_req(dat_req), .dat_we(dat_we), .dat_addr(dat_addr), .dat_size(dat_size),
        .dat_signed(dat_signed), .dat_wdata(dat_wdata), .dat_ack(dat_ack), .dat_rdata(dat_rdata),
        .err(err), .busy(busy), .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_count(mem_byte_count), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_rdata_rdy(mem_rdata_rdy), .mem_wdata_rdy(mem_wdata_rdy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // cycle 0 is the negedge the request was driven on; counts strobes until the ack
    task automatic observe(input int limit);
        logic first = 1;
        ack_cyc = -1; rd_cnt = 0; wr_cnt = 0;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if ((mem_read || mem_write) && first) begin
                first = 0; bc_seen = mem_byte_count; addr_seen = mem_addr; wdata_seen = mem_wdata;
            end
            rd_cnt += int'(mem_read);
            wr_cnt += int'(mem_write);
            if (fetch_ack || dat_ack) begin
                ack_cyc = k; got_fetch = fetch_ack; got_dat = dat_ack; got_err = err;
                got_data = fetch_ack ? fetch_data : dat_rdata;
                if (fetch_ack) fetch_req = 0;
                if (dat_ack) dat_req = 0;
                break;
            end
        end
        if (ack_cyc < 0) begin fetch_req = 0; dat_req = 0; end
    endtask

    task automatic load(input logic [1:0] sz, input logic sg, input logic [31:0] raw,
                        input logic [31:0] exp, input string tag);
        @(negedge clk);
        rsp_data = raw; dat_we = 0; dat_size = sz; dat_signed = sg; dat_addr = 24'h000040; dat_req = 1;
        observe(20);
        chk({tag, "_ack_cyc"}, ack_cyc, 4 + int'(sz));
        chk({tag, "_bc"}, 32'(bc_seen), 32'(sz));
        chk({tag, "_rdata"}, got_data, exp);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ctl", {26'd0, busy, mem_read, mem_write, fetch_ack, dat_ack, err}, 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_data", fetch_data | dat_rdata | mem_wdata, 0);
        rst = 1;

        // 1: 4-byte fetch
        @(negedge clk);
        rsp_data = 32'h12345678; fetch_addr = 24'h000100; fetch_req = 1;
        observe(20);
        chk("f1_ack_cyc", ack_cyc, 7);
        chk("f1_rd_cnt", rd_cnt, 6);
        chk("f1_port", {got_fetch, got_dat}, 2'b10);
        chk("f1_data", got_data, 32'h12345678);
        chk("f1_err", 32'(got_err), 0);
        chk("f1_bc", 32'(bc_seen), 3);
        chk("f1_addr", 32'(addr_seen), 32'h100);
        chk("f1_strobe_at_ack", {mem_read, mem_write}, 0);
        @(negedge clk);
        chk("f1_idle", {busy, fetch_ack}, 0);

        // 2: extension
        load(2'd0, 1, 32'h000000F0, 32'hFFFFFFF0, "ld_b_s");
        load(2'd0, 0, 32'h000000F0, 32'h000000F0, "ld_b_u");
        load(2'd0, 1, 32'hFFFFFF7F, 32'h0000007F, "ld_b_spos");
        load(2'd1, 1, 32'h00018000, 32'hFFFF8000, "ld_h_s");
        load(2'd2, 0, 32'hFF876543, 32'h00876543, "ld_3_u");
        load(2'd3, 1, 32'h87654321, 32'h87654321, "ld_w_s");

        // 3: simultaneous requests, data first
        @(negedge clk);
        rsp_data = 32'hCAFEF00D; dat_we = 0; dat_size = 2'd3; dat_signed = 0; dat_addr = 24'h000300;
        fetch_addr = 24'h000200; dat_req = 1; fetch_req = 1;
        observe(20);
        chk("arb_first_port", {got_fetch, got_dat}, 2'b01);
        chk("arb_first_data", got_data, 32'hCAFEF00D);
        chk("arb_first_addr", 32'(addr_seen), 32'h300);
        chk("arb_gap1", {mem_read, mem_write}, 0);
        rsp_data = 32'h11223344;
        @(negedge clk);
        chk("arb_gap2", {busy, mem_read, mem_write}, 0);
        observe(20);
        chk("arb_second_port", {got_fetch, got_dat}, 2'b10);
        chk("arb_second_cyc", ack_cyc, 7);
        chk("arb_second_addr", 32'(addr_seen), 32'h200);
        chk("arb_second_data", got_data, 32'h11223344);

        // 4: store with spurious read-ready held high
        @(negedge clk);
        noise_r = 1; rsp_data = 32'hA5A5A5A5;
        dat_we = 1; dat_size = 2'd1; dat_addr = 24'h000010; dat_wdata = 32'h0000BEEF; dat_req = 1;
        observe(20);
        chk("st_ack_cyc", ack_cyc, 5);
        chk("st_wr_cnt", wr_cnt, 4);
        chk("st_rd_cnt", rd_cnt, 0);
        chk("st_port", {got_fetch, got_dat}, 2'b01);
        chk("st_rdata", got_data, 0);
        chk("st_bc", 32'(bc_seen), 1);
        chk("st_addr", 32'(addr_seen), 32'h10);
        chk("st_wdata", wdata_seen, 32'h0000BEEF);
        noise_r = 0; dat_we = 0;

        // 5: silent responder times out
        @(negedge clk);
        rsp_en = 0; rsp_data = 32'hDEADBEEF; fetch_addr = 24'h000400; fetch_req = 1;
        observe(100);
        chk("to_ack_cyc", ack_cyc, 65);
        chk("to_rd_cnt", rd_cnt, 64);
        chk("to_err", 32'(got_err), 1);
        chk("to_data", got_data, 0);
        rsp_en = 1;
        @(negedge clk);
        chk("to_err_clear", {busy, err}, 0);

        // 6: reset mid-transfer, then stale readies
        @(negedge clk);
        rsp_data = 32'h0BADF00D; dat_we = 0; dat_size = 2'd3; dat_addr = 24'h000500; dat_req = 1;
        repeat (2) @(negedge clk);
        chk("rb_in_bus", {busy, mem_read}, 2'b11);
        rst = 0; dat_req = 0;
        @(negedge clk);
        chk("rb_ctl", {26'd0, busy, mem_read, mem_write, fetch_ack, dat_ack, err}, 0);
        chk("rb_addr", 32'(mem_addr), 0);
        rst = 1; noise_r = 1; noise_w = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stale_ready", {busy, fetch_ack, dat_ack, err}, 0);
        end
        noise_r = 0; noise_w = 0;
        rsp_data = 32'h55AA33CC; fetch_addr = 24'h000600; fetch_req = 1;
        observe(20);
        chk("rec_ack_cyc", ack_cyc, 7);
        chk("rec_data", got_data, 32'h55AA33CC);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
